// File: rtl/sat_predictor_bank.sv
// Bank of saturating up/down counters for branch prediction, with registered lookup
// and a multi-cycle clear sequence that walks every entry back to INIT.
module sat_predictor_bank #(
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned INIT    = 2 ** (CTR_W - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic             pred_conf,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             clear,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [CTR_W-1:0] CtrMax  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CtrInit = CTR_W'(INIT);
  localparam logic [IDX_W-1:0] PtrLast = IDX_W'(ENTRIES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d [ENTRIES];
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic             pred_conf_q, pred_conf_d;

  logic [CTR_W-1:0] lk_ctr;
  logic [CTR_W-1:0] upd_ctr;

  assign lk_ctr  = ctr_q[lk_idx];
  assign upd_ctr = ctr_q[upd_idx];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ctr_d        = ctr_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_conf_d  = pred_conf_q;
    unique case (state_q)
      StIdle: begin
        // Lookup reads the pre-update value; no bypass from a same-cycle update.
        if (lk_valid) begin
          pred_valid_d = 1'b1;
          pred_taken_d = lk_ctr[CTR_W-1];
          pred_conf_d  = (lk_ctr == '0) || (lk_ctr == CtrMax);
        end
        if (upd_valid) begin
          if (upd_taken && (upd_ctr != CtrMax)) begin
            ctr_d[upd_idx] = upd_ctr + 1'b1;
          end else if (!upd_taken && (upd_ctr != '0)) begin
            ctr_d[upd_idx] = upd_ctr - 1'b1;
          end
        end
        if (clear) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        ctr_d[ptr_q] = CtrInit;
        ptr_d        = ptr_q + 1'b1;
        if (ptr_q == PtrLast) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_conf_q  <= 1'b0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CtrInit;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_conf_q  <= pred_conf_d;
      ctr_q        <= ctr_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_conf  = pred_conf_q;
  // Decoded straight from state so an asynchronous reset drops it immediately.
  assign busy       = (state_q == StClear);

endmodule

// File: tb/tb_sat_predictor_bank.sv
// Directed plus randomized bench for sat_predictor_bank against an arithmetic reference model.
module tb_sat_predictor_bank;

  localparam int CTR_W   = 2;
  localparam int ENTRIES = 4;
  localparam int IDX_W   = 2;
  localparam int INIT    = 2;
  localparam int MAXV    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lk_valid = 1'b0;
  logic [IDX_W-1:0] lk_idx = '0;
  logic             pred_valid;
  logic             pred_taken;
  logic             pred_conf;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic             clear = 1'b0;
  logic             busy;

  sat_predictor_bank #(
    .CTR_W  (CTR_W),
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W),
    .INIT   (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lk_valid  (lk_valid),
    .lk_idx    (lk_idx),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_conf (pred_conf),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken),
    .clear     (clear),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer counters and a count of clear cycles still to run.
  int mdl [ENTRIES];
  int clr_left;
  bit m_pv, m_pt, m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mdl[i]) mdl[i] = INIT;
    clr_left = 0;
    m_pv = 1'b0;
    m_pt = 1'b0;
    m_pc = 1'b0;
  endtask

  task automatic step(input bit lkv, input int lki, input bit uv, input int ui, input bit ut,
                      input bit clr, input string tag);
    lk_valid  = lkv;
    lk_idx    = lki[IDX_W-1:0];
    upd_valid = uv;
    upd_idx   = ui[IDX_W-1:0];
    upd_taken = ut;
    clear     = clr;
    @(posedge clk);
    #1;
    if (clr_left == 0) begin
      m_pv = lkv;
      if (lkv) begin
        m_pt = (mdl[lki] >= INIT);
        m_pc = (mdl[lki] == 0) || (mdl[lki] == MAXV);
      end
      if (uv) begin
        if (ut) mdl[ui] = (mdl[ui] < MAXV) ? mdl[ui] + 1 : MAXV;
        else    mdl[ui] = (mdl[ui] > 0) ? mdl[ui] - 1 : 0;
      end
      if (clr) clr_left = ENTRIES;
    end else begin
      m_pv = 1'b0;
      clr_left--;
      if (clr_left == 0) foreach (mdl[i]) mdl[i] = INIT;
    end
    check({tag, ".valid"}, 32'(pred_valid), 32'(m_pv));
    check({tag, ".taken"}, 32'(pred_taken), 32'(m_pt));
    check({tag, ".conf"},  32'(pred_conf),  32'(m_pc));
    check({tag, ".busy"},  32'(busy),       32'(clr_left != 0));
  endtask

  task automatic idle(input string tag);
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic lookup(input int i, input string tag);
    step(1'b1, i, 1'b0, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic train(input int i, input bit t, input string tag);
    step(1'b0, 0, 1'b1, i, t, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst.valid", 32'(pred_valid), 32'd0);
    check("rst.taken", 32'(pred_taken), 32'd0);
    check("rst.conf",  32'(pred_conf),  32'd0);
    check("rst.busy",  32'(busy),       32'd0);
    rst = 1'b0;

    // First edge after reset release accepts a lookup.
    lookup(0, "l0");
    check("l0.lit", {pred_valid, pred_taken, pred_conf}, 32'b110);

    for (int k = 0; k < 4; k++) train(1, 1'b1, "inc1");
    lookup(1, "l1");
    check("l1.lit", {pred_taken, pred_conf}, 32'b11);

    for (int k = 0; k < 3; k++) train(2, 1'b0, "dec2");
    lookup(2, "l2");
    check("l2.lit", {pred_taken, pred_conf}, 32'b01);

    step(1'b1, 3, 1'b1, 3, 1'b0, 1'b0, "same3");
    check("same3.lit", 32'(pred_taken), 32'd1);
    lookup(3, "after3");
    check("after3.lit", 32'(pred_taken), 32'd0);

    train(0, 1'b1, "inc0");
    lookup(0, "l0b");
    check("l0b.conf", 32'(pred_conf), 32'd1);
    // Clear accepted together with an update and a lookup; then hammer it while busy.
    step(1'b1, 1, 1'b1, 1, 1'b0, 1'b1, "clr");
    for (int k = 0; k < ENTRIES; k++) step(1'b1, k, 1'b1, k, 1'b1, 1'b1, "busy");
    check("clr.done", 32'(busy), 32'd0);
    for (int k = 0; k < ENTRIES; k++) begin
      lookup(k, "postclr");
      check("postclr.lit", {pred_taken, pred_conf}, 32'b10);
    end

    // Reset in the middle of a clear sequence.
    train(2, 1'b1, "pre.a");
    train(3, 1'b0, "pre.b");
    train(3, 1'b0, "pre.c");
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, "clr2");
    idle("clr2.c1");
    #1;
    rst = 1'b1;
    #1;
    check("arst.busy",  32'(busy),       32'd0);
    check("arst.valid", 32'(pred_valid), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("arst.hold", {pred_valid, pred_taken, pred_conf, busy}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      lookup(k, "postrst");
      check("postrst.lit", {pred_taken, pred_conf}, 32'b10);
    end

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, ENTRIES - 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, ENTRIES - 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
